// File: rtl/demux_1_8_deser.sv
// 1:8 serial-to-parallel deserializer with one-word output register and a
// one-word parking slot; bits arriving while parked are dropped and flagged.
module demux_1_8_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       din,
  input  logic       din_valid,
  output logic [2:0] s,
  output logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       full,
  output logic       overrun
);

  // state   | meaning
  // COLLECT | accepting serial bits into staging slots
  // FULL    | complete word parked in staging, waiting for the output to free
  typedef enum logic {ST_COLLECT = 1'b0, ST_FULL = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_stage;
  logic [2:0] r_slot;
  logic [7:0] r_y;
  logic       r_out_valid;
  logic       r_overrun;

  logic       w_free;
  logic       w_accept;
  logic       w_last;
  logic       w_load_direct;
  logic       w_park;
  logic       w_transfer;
  logic       w_load;
  logic [7:0] w_word;

  // staging keeps bits in arrival (slot) order; bit order is applied only at load
  function automatic logic [7:0] f_order(input logic [7:0] slots);
    logic [7:0] res;
    res = slots;
    if (!LSB_FIRST) begin
      for (int k = 0; k < 8; k++) res[7-k] = slots[k];
    end
    return res;
  endfunction

  assign w_free        = ~r_out_valid | out_ready;
  assign w_accept      = (r_state == ST_COLLECT) & din_valid;
  assign w_last        = w_accept & (r_slot == 3'd7);
  assign w_load_direct = w_last & w_free;
  assign w_park        = w_last & ~w_free;
  assign w_transfer    = (r_state == ST_FULL) & w_free;
  assign w_load        = w_load_direct | w_transfer;
  assign w_word        = {din, r_stage[6:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= ST_COLLECT;
    else if (clr) r_state <= ST_COLLECT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_park)     w_state_nxt = ST_FULL;
      ST_FULL:    if (w_transfer) w_state_nxt = ST_COLLECT;
      default:                    w_state_nxt = ST_COLLECT;
    endcase
  end

  always_comb begin
    full = (r_state == ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage     <= 8'h00;
      r_slot      <= 3'd0;
      r_y         <= 8'h00;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clr) begin
      r_stage     <= 8'h00;
      r_slot      <= 3'd0;
      r_y         <= 8'h00;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_slot <= 3'd0;
          if (w_park) r_stage <= w_word;
        end else begin
          r_stage[r_slot] <= din;
          r_slot          <= r_slot + 3'd1;
        end
      end
      if (w_load) r_y <= w_transfer ? f_order(r_stage) : f_order(w_word);
      // a load on a consume edge keeps out_valid high with no bubble
      if (w_load)         r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
      if ((r_state == ST_FULL) && din_valid) r_overrun <= 1'b1;
    end
  end

  assign s         = r_slot;
  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a word-level behavioural model for both bit orders.
module tb_demux_1_8_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] s_l, s_m;
  logic [7:0] y_l, y_m;
  logic       ov_l, ov_m, full_l, full_m, orun_l, orun_m;

  int n_err = 0;
  int n_checks = 0;

  // model state: slot-ordered bits of the word being collected
  int         m_cnt;
  logic       m_bits [8];
  logic       m_full;
  logic [7:0] m_pend;
  logic [7:0] m_y;
  logic       m_ov;
  logic       m_orun;

  always #5 clk = ~clk;

  demux_1_8_deser #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .s(s_l), .y(y_l), .out_valid(ov_l), .out_ready(out_ready),
    .full(full_l), .overrun(orun_l));

  demux_1_8_deser #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .s(s_m), .y(y_m), .out_valid(ov_m), .out_ready(out_ready),
    .full(full_m), .overrun(orun_m));

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < 8; k++) m_bits[k] = 1'b0;
    m_full = 1'b0; m_pend = 8'h00; m_y = 8'h00; m_ov = 1'b0; m_orun = 1'b0;
  endtask

  // one clock edge worth of behaviour, evaluated from pre-edge values
  task automatic model_edge(input logic d, input logic dv, input logic rdy, input logic c);
    logic       free, consume, load;
    logic [7:0] word;
    if (c) begin
      model_reset();
      return;
    end
    free    = !m_ov || rdy;
    consume = m_ov && rdy;
    load    = 1'b0;
    if (!m_full) begin
      if (dv) begin
        m_bits[m_cnt] = d;
        if (m_cnt == 7) begin
          word = 8'h00;
          for (int k = 0; k < 8; k++) word = word + (8'(m_bits[k]) << k);
          m_cnt = 0;
          if (free) begin m_y = word; load = 1'b1; end
          else begin m_pend = word; m_full = 1'b1; end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end else begin
      if (dv) m_orun = 1'b1;
      if (free) begin m_y = m_pend; m_full = 1'b0; load = 1'b1; end
    end
    if (load) m_ov = 1'b1;
    else if (consume) m_ov = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s"},        {5'd0, s_l},    8'(m_cnt));
    chk({tag, ".y"},        y_l,            m_y);
    chk({tag, ".out_valid"}, {7'd0, ov_l},  {7'd0, m_ov});
    chk({tag, ".full"},     {7'd0, full_l}, {7'd0, m_full});
    chk({tag, ".overrun"},  {7'd0, orun_l}, {7'd0, m_orun});
    chk({tag, ".y_msb"},    y_m,            rev8(m_y));
    chk({tag, ".s_msb"},    {5'd0, s_m},    8'(m_cnt));
    chk({tag, ".full_msb"}, {7'd0, full_m}, {7'd0, m_full});
  endtask

  task automatic step(input logic d, input logic dv, input logic rdy, input logic c, input string tag);
    din = d; din_valid = dv; out_ready = rdy; clr = c;
    model_edge(d, dv, rdy, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input string tag);
    for (int k = 0; k < 8; k++) step(w[k], 1'b1, rdy, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // basic LSB/MSB word with s progression
    for (int k = 0; k < 8; k++) begin
      chk("s_seq", {5'd0, s_l}, 8'(k));
      step(k[0] ? 1'b0 : 1'b0, 1'b0, 1'b1, 1'b0, "idle");
      din = 1'b0;
      step((8'hB6 >> k) & 8'h01 ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0, "b6");
    end
    chk("b6_y", y_l, 8'hB6);
    chk("b6_y_msb", y_m, 8'h6D);
    chk("b6_valid", {7'd0, ov_l}, 8'h01);
    chk("b6_s_wrap", {5'd0, s_l}, 8'h00);

    // backpressure into FULL, overrun, drain
    step(1'b0, 1'b0, 1'b0, 1'b1, "clr");
    send_word(8'hB6, 1'b0, "bp1");
    send_word(8'h3C, 1'b0, "bp2");
    chk("bp_full", {7'd0, full_l}, 8'h01);
    chk("bp_y", y_l, 8'hB6);
    for (int k = 0; k < 3; k++) step(k[0], 1'b1, 1'b0, 1'b0, "drop");
    chk("orun", {7'd0, orun_l}, 8'h01);
    chk("orun_s", {5'd0, s_l}, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, "drain");
    chk("drain_y", y_l, 8'h3C);
    chk("drain_full", {7'd0, full_l}, 8'h00);
    chk("drain_valid", {7'd0, ov_l}, 8'h01);
    send_word(8'hFF, 1'b1, "ff");
    chk("ff_y", y_l, 8'hFF);
    chk("orun_sticky", {7'd0, orun_l}, 8'h01);

    // consume coinciding with next word load
    for (int k = 0; k < 7; k++) step((8'h5A >> k) & 8'h01 ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, "5a");
    step(1'b0, 1'b1, 1'b1, 1'b0, "5a_last");
    chk("nobubble_valid", {7'd0, ov_l}, 8'h01);
    chk("nobubble_y", y_l, 8'h5A);

    // asynchronous reset mid-word
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "part");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(8'h81, 1'b1, "81");
    chk("81_y", y_l, 8'h81);
    chk("81_y_msb", y_m, 8'h81);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
